// File: rtl/snake_pkg.sv
// Shared direction encoding and key mapping for the snake input stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package snake_pkg;

  // Opposite directions differ only in bit 1, so a reversal test is one XOR.
  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  // Bit positions of each button on the active-low KEY bus.
  localparam int KEY_RIGHT_BIT = 0;
  localparam int KEY_DOWN_BIT  = 1;
  localparam int KEY_UP_BIT    = 2;
  localparam int KEY_LEFT_BIT  = 3;

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic [1:0] diff;
    diff = a ^ b;
    return (diff == 2'b10);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, debouncer, and a one-cycle press pulse on release->press.
// Latency: press pulses 2 + DEBOUNCE_CYCLES cycles after a clean KEY falling edge.
// Backpressure: none; the pulse is single-cycle and is dropped if the consumer ignores it.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain; idle level is released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with the stable one long enough;
  // the press pulse is raised on the same edge the stable level drops to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced button presses into validated turns, queues up to two, and paces steps to the core.
// Latency: one step request per STEP_CYCLES while enabled; a queued turn is applied on the next tick.
// Backpressure: step_req holds until step_ack; ticks during a pending request set sticky overrun.
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [3:0] KEY,
  input  logic       enable,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  output logic       overrun
);

  import snake_pkg::*;

  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [3:0]    press;
  logic          press_vld;
  dir_t          press_dir;
  dir_t          cur_dir;
  dir_t          q0;
  dir_t          q1;
  logic [1:0]    q_cnt;
  dir_t          ref_dir;
  logic          tick;
  logic          pop;
  logic          push;
  logic [SW-1:0] step_cnt;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (CLOCK_50),
      .rst    (rst),
      .key_raw(KEY[i]),
      .press  (press[i])
    );
  end

  assign step_dir = cur_dir;

  // Keep at most one press per cycle, UP > DOWN > LEFT > RIGHT.
  always_comb begin
    press_vld = 1'b1;
    press_dir = UP;
    if (press[KEY_UP_BIT]) begin
      press_dir = UP;
    end else if (press[KEY_DOWN_BIT]) begin
      press_dir = DOWN;
    end else if (press[KEY_LEFT_BIT]) begin
      press_dir = LEFT;
    end else if (press[KEY_RIGHT_BIT]) begin
      press_dir = RIGHT;
    end else begin
      press_vld = 1'b0;
    end
  end

  // A new turn is judged against the last queued turn, or the current heading when
  // nothing is queued. A pop in the same cycle frees a slot, so a full queue can still
  // take the press and stay full.
  assign ref_dir = (q_cnt == 2'd0) ? cur_dir : ((q_cnt == 2'd2) ? q1 : q0);
  assign tick    = enable && (step_cnt == STEP_LAST);
  assign pop     = tick && !step_req && (q_cnt != 2'd0);
  assign push    = enable && press_vld && ((q_cnt != 2'd2) || pop) &&
                   (press_dir != ref_dir) && !is_opposite(press_dir, ref_dir);

  // Step period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (!enable || (step_cnt == STEP_LAST)) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Two-entry shift queue: q0 is the head, q1 only meaningful when full; flushed when disabled.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      q0    <= RIGHT;
      q1    <= RIGHT;
      q_cnt <= 2'd0;
    end else if (!enable) begin
      q_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q0 <= press_dir;
          end else begin
            q0 <= q1;
            q1 <= press_dir;
          end
        end
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= press_dir;
          else q1 <= press_dir;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Request/ack handshake; an ack landing with a tick still counts that tick as overrun.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      step_req <= 1'b0;
      cur_dir  <= RIGHT;
      overrun  <= 1'b0;
    end else begin
      if (step_req && step_ack) step_req <= 1'b0;
      if (tick) begin
        if (step_req) begin
          overrun <= 1'b1;
        end else begin
          step_req <= 1'b1;
          if (q_cnt != 2'd0) cur_dir <= q0;
        end
      end
    end
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Input stage directly upstream of the snake_game core FSM.
- Conditions the raw push buttons KEY[3:0] into clean, validated turn commands and paces the game.
- Buffers up to two turns; issues one movement step per period to the core over a req/ack handshake, carrying the direction to apply.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a key change is accepted (20 ms at 50 MHz)
STEP_CYCLES, 5_000_000, cycles between movement steps (10 Hz at 50 MHz); must be >= 2

Ports:
CLOCK_50  in   1  system clock, 50 MHz
rst       in   1  asynchronous active-high reset (driven from SW[0] at top level)
KEY       in   4  raw buttons, active-low, asynchronous: [0]=right, [1]=down, [2]=up, [3]=left
enable    in   1  game running; low while core is in idle/GAME_END
step_req  out  1  step request to core; held until acknowledged
step_dir  out  2  direction for the requested step; stable while step_req=1
step_ack  in   1  core has consumed the step
overrun   out  1  sticky: a step period elapsed while step_req was still pending

Behaviour:
Reset (async, active-high). All registers take these values immediately:
- step_req=0, step_dir=RIGHT, overrun=0.
- Queue empty; step counter 0.
- Synchronizers and debounced key states = 1 (released); debounce counters 0.

Input conditioning, per key:
- 2-flop synchronizer, then debouncer.
- Debounce counter increments while the synced value differs from the stable value; clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the stable value flips and the counter clears.
- A press event is a one-cycle pulse on a stable 1->0 transition. Releases generate nothing.
- Latency from KEY edge to press pulse = 2 + DEBOUNCE_CYCLES cycles.

Same-cycle presses:
- Only one press is accepted per cycle; priority UP > DOWN > LEFT > RIGHT.
- All other presses that cycle are dropped.

Turn queue (2-entry FIFO of directions). A press is pushed only if enable=1, the queue is not full, and the pressed direction is neither equal nor opposite to the reference:
- Reference = queue tail if the queue is non-empty, otherwise step_dir.
- Equal or opposite presses are silently dropped (no 180-degree reversal, no duplicates).
- A press arriving when the queue is full is dropped.

Step timer:
- Counts 0..STEP_CYCLES-1 while enable=1; held at 0 while enable=0. Wraps to 0.
- A tick occurs when the counter is at STEP_CYCLES-1.
- On a tick with step_req=0: step_req<=1 next cycle. If the queue is non-empty, step_dir<=head and head is popped in the same edge; otherwise step_dir is unchanged.
- On a tick with step_req=1: no new request, no pop, overrun<=1. overrun stays 1 until reset.

Handshake:
- step_ack sampled 1 while step_req=1 -> step_req<=0 next edge.
- step_ack while step_req=0 is ignored.
- Back-to-back ack and tick in the same cycle: ack wins; the tick is treated as overrun.

Simultaneous push and pop:
- Both happen. The push validity check uses the pre-pop tail.
- Count: full stays full, 1 stays 1.

enable falling:
- Queue is flushed and the counter is cleared.
- A pending step_req completes normally and step_dir is held.
- Presses are ignored while enable=0.

Reset mid-operation: all state returns to reset values immediately, including a pending request and the queue contents.

Decomposition:
- snake_pkg:
  - dir_t enum, 2 bits: UP=2'b00, RIGHT=2'b01, DOWN=2'b10, LEFT=2'b11. Opposite = XOR 2'b10.
  - Function is_opposite(a,b).
  - KEY-bit-to-dir_t mapping constants.
- Sub-module key_debounce (synchronizer + debouncer + press pulse, DEBOUNCE_CYCLES parameter), instantiated 4x.
- Queue, timer and handshake stay in snake_dir_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=10):
1. Reset, enable=1, no keys, ack one cycle after each req -> step_req rises every 10 cycles; step_dir=RIGHT (01) throughout; overrun=0.
2. KEY[2] low for 8 cycles during period 1 -> press after 6 cycles; next step has step_dir=UP (00). KEY[3] pressed next -> following step LEFT (11).
3. Heading RIGHT, press LEFT -> dropped, step_dir stays 01. Press DOWN then UP within one period -> queue holds DOWN only (UP is opposite of tail); next steps DOWN, DOWN.
4. KEY bounce: toggle KEY[1] every 2 cycles for 12 cycles, then release -> no press pulse, queue unchanged.
5. Never assert step_ack -> step_req stays 1 and step_dir is frozen; overrun=1 after the second tick. Assert rst mid-period -> step_req=0, overrun=0, step_dir=RIGHT, queue empty.
6. Press DOWN, LEFT, UP within one period -> queue [DOWN, LEFT], UP dropped (full). Steps apply DOWN, then LEFT. enable=0 with 1 entry queued -> queue flushed; after re-enable, step_dir is unchanged.
